// File: rtl/mbus_arbiter.sv
// Two-master arbiter and sequencer for the shared memory bus: one transfer at a time,
// read data captured after a fixed slave latency, and a one-cycle ack to the owner.
module mbus_arbiter #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 2,
    parameter int CW      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             m0_req,
    input  logic [WIDTH-1:0] m0_addr,
    input  logic [WIDTH-1:0] m0_dout,
    input  logic             m0_wen,
    input  logic             m0_lock,
    output logic [WIDTH-1:0] m0_din,
    output logic             m0_ack,
    input  logic             m1_req,
    input  logic [WIDTH-1:0] m1_addr,
    input  logic [WIDTH-1:0] m1_dout,
    input  logic             m1_wen,
    output logic [WIDTH-1:0] m1_din,
    output logic             m1_ack,
    output logic [WIDTH-1:0] s_addr,
    output logic [WIDTH-1:0] s_dout,
    output logic             s_wen,
    input  logic [WIDTH-1:0] s_din,
    output logic [1:0]       gnt
);

    if (LATENCY < 1 || LATENCY >= (1 << CW)) begin : g_latency_check
        $error("mbus_arbiter: LATENCY must lie in [1, 2**CW-1] so the counter never wraps");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CW-1:0] LAST_CNT = CW'(LATENCY - 1);

    state_t           state_q, state_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             lock_q, lock_d;
    logic [WIDTH-1:0] m0_din_q, m0_din_d;
    logic [WIDTH-1:0] m1_din_q, m1_din_d;
    logic             m0_ack_q, m0_ack_d;
    logic             m1_ack_q, m1_ack_d;
    logic             sel_wen;

    // gnt_q is non-zero only during ACC, so the bus mux doubles as the idle/done zeroing.
    assign sel_wen = gnt_q[0] ? m0_wen : m1_wen;
    assign s_addr  = gnt_q[0] ? m0_addr : (gnt_q[1] ? m1_addr : '0);
    assign s_dout  = gnt_q[0] ? m0_dout : (gnt_q[1] ? m1_dout : '0);
    assign s_wen   = (gnt_q != 2'b00) && (cnt_q == '0) && sel_wen;

    assign gnt    = gnt_q;
    assign m0_din = m0_din_q;
    assign m1_din = m1_din_q;
    assign m0_ack = m0_ack_q;
    assign m1_ack = m1_ack_q;

    always_comb begin
        // NOTE: every variable gets a default first so no path through the case infers a latch.
        state_d  = state_q;
        gnt_d    = gnt_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        lock_d   = lock_q;
        m0_din_d = m0_din_q;
        m1_din_d = m1_din_q;
        m0_ack_d = 1'b0;
        m1_ack_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    if (lock_q && m0_req)      gnt_d = 2'b01;
                    else if (m0_req && m1_req) gnt_d = last_q ? 2'b01 : 2'b10;
                    else if (m0_req)           gnt_d = 2'b01;
                    else                       gnt_d = 2'b10;
                    cnt_d   = '0;
                    state_d = ACC;
                end
            end
            ACC: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    if (!sel_wen) begin
                        if (gnt_q[0]) m0_din_d = s_din;
                        else          m1_din_d = s_din;
                    end
                    m0_ack_d = gnt_q[0];
                    m1_ack_d = gnt_q[1];
                    gnt_d    = 2'b00;
                    state_d  = DONE;
                end
            end
            DONE: begin
                // The ack flags identify the master that just finished.
                last_d  = m1_ack_q;
                lock_d  = m0_ack_q && m0_lock;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            gnt_q    <= 2'b00;
            cnt_q    <= '0;
            last_q   <= 1'b1;
            lock_q   <= 1'b0;
            m0_din_q <= '0;
            m1_din_q <= '0;
            m0_ack_q <= 1'b0;
            m1_ack_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            lock_q   <= lock_d;
            m0_din_q <= m0_din_d;
            m1_din_q <= m1_din_d;
            m0_ack_q <= m0_ack_d;
            m1_ack_q <= m1_ack_d;
        end
    end

endmodule

// File: tb/tb_mbus_arbiter.sv
// Bench for mbus_arbiter: directed scenarios with literal expectations, then random
// master traffic, all compared every cycle against a transaction-level model.
module tb_mbus_arbiter;

    localparam int W = 32;
    localparam int L = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         m0_req = 1'b0, m0_wen = 1'b0, m0_lock = 1'b0;
    logic [W-1:0] m0_addr = '0, m0_dout = '0;
    logic         m1_req = 1'b0, m1_wen = 1'b0;
    logic [W-1:0] m1_addr = '0, m1_dout = '0;
    logic [W-1:0] s_din = '0;
    logic [W-1:0] m0_din, m1_din, s_addr, s_dout;
    logic         m0_ack, m1_ack, s_wen;
    logic [1:0]   gnt;

    mbus_arbiter #(.WIDTH(W), .LATENCY(L), .CW(4)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_dout(m0_dout), .m0_wen(m0_wen),
        .m0_lock(m0_lock), .m0_din(m0_din), .m0_ack(m0_ack),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_dout(m1_dout), .m1_wen(m1_wen),
        .m1_din(m1_din), .m1_ack(m1_ack),
        .s_addr(s_addr), .s_dout(s_dout), .s_wen(s_wen), .s_din(s_din), .gnt(gnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Transaction model: ph = 0 idle, 1..L access cycles, L+1 ack cycle.
    int           ph = 0;
    int           own = 0;
    int           last_m = 1;
    bit           lock_m = 1'b0;
    logic [W-1:0] t_addr, t_dout;
    logic         t_wen;
    logic [W-1:0] din_m [2];
    bit           upd [2];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        ph = 0; own = 0; last_m = 1; lock_m = 1'b0;
        din_m[0] = '0; din_m[1] = '0;
        upd[0] = 1'b0; upd[1] = 1'b0;
    endtask

    task automatic model_step();
        if (ph == 0) begin
            if (m0_req || m1_req) begin
                if (lock_m && m0_req)      own = 0;
                else if (m0_req && m1_req) own = 1 - last_m;
                else                       own = m0_req ? 0 : 1;
                t_addr = (own == 0) ? m0_addr : m1_addr;
                t_dout = (own == 0) ? m0_dout : m1_dout;
                t_wen  = (own == 0) ? m0_wen  : m1_wen;
                ph = 1;
            end
        end else if (ph <= L) begin
            if (ph == L && !t_wen) din_m[own] = s_din;
            ph++;
        end else begin
            last_m = own;
            lock_m = (own == 0) && m0_lock;
            ph = 0;
        end
    endtask

    // Advance the model on the current inputs, cross the clock edge, compare everything.
    task automatic tick();
        bit acc;
        model_step();
        @(posedge clk);
        #1;
        acc = (ph >= 1) && (ph <= L);
        check("gnt",    {30'b0, gnt},   acc ? ((own == 0) ? 32'd1 : 32'd2) : 32'd0);
        check("s_addr", s_addr,         acc ? t_addr : '0);
        check("s_dout", s_dout,         acc ? t_dout : '0);
        check("s_wen",  {31'b0, s_wen}, {31'b0, (ph == 1) && t_wen});
        check("m0_ack", {31'b0, m0_ack}, {31'b0, (ph == L + 1) && (own == 0)});
        check("m1_ack", {31'b0, m1_ack}, {31'b0, (ph == L + 1) && (own == 1)});
        check("m0_din", m0_din, din_m[0]);
        check("m1_din", m1_din, din_m[1]);
    endtask

    // Asserts reset mid-cycle; outputs must clear without waiting for a clock edge.
    task automatic do_reset();
        reset = 1'b0;
        #1;
        check("rst_gnt",    {30'b0, gnt},    '0);
        check("rst_s_wen",  {31'b0, s_wen},  '0);
        check("rst_s_addr", s_addr,          '0);
        check("rst_s_dout", s_dout,          '0);
        check("rst_m0_ack", {31'b0, m0_ack}, '0);
        check("rst_m1_ack", {31'b0, m1_ack}, '0);
        check("rst_m0_din", m0_din,          '0);
        check("rst_m1_din", m1_din,          '0);
        model_reset();
        m0_req = 1'b0; m0_lock = 1'b0; m1_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic new_xfer(input int i, input bit req);
        if (i == 0) begin
            m0_req = req; m0_addr = $urandom; m0_dout = $urandom;
            m0_wen = $urandom_range(0, 1); m0_lock = $urandom_range(0, 1);
        end else begin
            m1_req = req; m1_addr = $urandom; m1_dout = $urandom;
            m1_wen = $urandom_range(0, 1);
        end
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Single read by m0.
        m0_req = 1'b1; m0_addr = 32'h10; m0_wen = 1'b0; s_din = 32'hDEADBEEF;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 1) begin
                check("rd_gnt1", {30'b0, gnt}, 32'd1);
                check("rd_addr", s_addr, 32'h10);
            end
            if (k == 2) check("rd_gnt2", {30'b0, gnt}, 32'd1);
            if (k <= 3) check("rd_nowen", {31'b0, s_wen}, '0);
            if (k == 3) begin
                check("rd_ack", {31'b0, m0_ack}, 32'd1);
                check("rd_din", m0_din, 32'hDEADBEEF);
                check("rd_gnt3", {30'b0, gnt}, '0);
                m0_req = 1'b0;
            end
        end

        // Single write by m1.
        m1_req = 1'b1; m1_addr = 32'hF000; m1_dout = 32'h12345678; m1_wen = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 1) begin
                check("wr_wen1", {31'b0, s_wen}, 32'd1);
                check("wr_addr", s_addr, 32'hF000);
                check("wr_dout", s_dout, 32'h12345678);
            end
            if (k == 2) check("wr_wen2", {31'b0, s_wen}, '0);
            if (k == 3) begin
                check("wr_ack", {31'b0, m1_ack}, 32'd1);
                check("wr_din", m1_din, '0);
                m1_req = 1'b0;
            end
        end

        // Simultaneous requests after reset alternate, m0 first.
        do_reset();
        m0_req = 1'b1; m0_addr = 32'h20; m0_wen = 1'b0;
        m1_req = 1'b1; m1_addr = 32'h30; m1_wen = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            s_din = $urandom;
            tick();
            if (k == 1 || k == 9)  check("rr_gnt_m0", {30'b0, gnt}, 32'd1);
            if (k == 5 || k == 13) check("rr_gnt_m1", {30'b0, gnt}, 32'd2);
            if (k == 15) begin m0_req = 1'b0; m1_req = 1'b0; end
        end

        // Locked read-modify-write by m0 while m1 waits.
        m0_req = 1'b1; m0_lock = 1'b1; m0_addr = 32'h100; m0_wen = 1'b0;
        m1_req = 1'b1; m1_addr = 32'h200; m1_wen = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            s_din = $urandom;
            tick();
            if (k == 1 || k == 5) check("lk_gnt_m0", {30'b0, gnt}, 32'd1);
            if (k == 9)           check("lk_gnt_m1", {30'b0, gnt}, 32'd2);
            if (k == 4) begin m0_wen = 1'b1; m0_dout = 32'hA5A5A5A5; m0_lock = 1'b0; end
            if (k == 8) m0_req = 1'b0;
            if (k == 11) m1_req = 1'b0;
        end

        // Back-to-back m0 transfers with a new address after each ack.
        m0_req = 1'b1; m0_addr = 32'h40; m0_wen = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            s_din = $urandom;
            tick();
            if (k == 1) check("b2b_addr0", s_addr, 32'h40);
            if (k == 5) check("b2b_addr1", s_addr, 32'h44);
            if (k == 9) check("b2b_addr2", s_addr, 32'h48);
            if (k == 4) m0_addr = 32'h44;
            if (k == 8) m0_addr = 32'h48;
            if (k == 11) m0_req = 1'b0;
        end

        // Reset in the second access cycle of an m1 write; m0 must win afterwards.
        m1_req = 1'b1; m1_addr = 32'h300; m1_dout = 32'h77; m1_wen = 1'b1;
        tick();
        check("ab_wen", {31'b0, s_wen}, 32'd1);
        tick();
        do_reset();
        m0_req = 1'b1; m0_addr = 32'h50; m0_wen = 1'b0;
        m1_req = 1'b1; m1_addr = 32'h60; m1_wen = 1'b0;
        tick();
        check("ab_gnt_m0", {30'b0, gnt}, 32'd1);

        // Random traffic: masters follow the handshake rules.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                if (ph == L + 1 && own == i) begin
                    upd[i] = 1'b1;
                end else if (upd[i]) begin
                    upd[i] = 1'b0;
                    new_xfer(i, ($urandom % 4) != 0);
                end else if (!(i == 0 ? m0_req : m1_req) && ($urandom % 3) == 0) begin
                    new_xfer(i, 1'b1);
                end
            end
            s_din = $urandom;
            tick();
        end

        m0_req = 1'b0; m1_req = 1'b0;
        repeat (8) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
